// File: rtl/sha256_round_ctrl_if.sv
// Message word stream between the padding front-end and the SHA-256 round
// controller.
//   blk_valid_i : front-end offers a word
//   blk_ready_o : controller takes the offered word this cycle
//   blk_word_i  : 32-bit message word, word 0 of the block first
//   blk_first_i : with word 0 only, 1 = first block of a message
// master = front-end, slave = controller.
interface sha256_round_ctrl_if #(
    parameter int n = 32
);
    logic         blk_valid_i;
    logic         blk_ready_o;
    logic [n-1:0] blk_word_i;
    logic         blk_first_i;

    modport master (
        output blk_valid_i,
        output blk_word_i,
        output blk_first_i,
        input  blk_ready_o
    );

    modport slave (
        input  blk_valid_i,
        input  blk_word_i,
        input  blk_first_i,
        output blk_ready_o
    );
endinterface

// File: rtl/sha256_round_ctrl.sv
// SHA-256 round sequencer. Collects a 512-bit block as sixteen words, expands
// the message schedule on the fly, steps the external round datapath once per
// round with W_t/K_t, and folds the final a..h into the running hash H.
//   clk_i, rst_i    : clock, asynchronous active-low reset
//   blk             : message word stream (slave side)
//   dp_load_o       : pulse, datapath loads dp_init_o into a..h
//   dp_init_o       : current H
//   dp_step_o       : pulse, datapath performs one round with dp_w_o/dp_k_o
//   dp_w_o, dp_k_o  : W_t and K_t of the current round
//   dp_state_i      : datapath a..h, sampled once at block end
//   digest_o        : current H
//   digest_valid_o  : pulse after H has been updated by a block
//   busy_o          : controller is not idle
module sha256_round_ctrl #(
    parameter int n         = 32,
    parameter int m         = 8,
    parameter int ROUND_LAT = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    sha256_round_ctrl_if.slave blk,
    output logic               dp_load_o,
    output logic [n-1:0]       dp_init_o [0:m-1],
    output logic               dp_step_o,
    output logic [n-1:0]       dp_w_o,
    output logic [n-1:0]       dp_k_o,
    input  logic [n-1:0]       dp_state_i [0:m-1],
    output logic [n-1:0]       digest_o [0:m-1],
    output logic               digest_valid_o,
    output logic               busy_o
);

    localparam logic [n-1:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [n-1:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Last value of the wait counter; WAIT is unreachable when ROUND_LAT is 0.
    localparam logic [2:0] LAT_LAST = (ROUND_LAT > 0) ? 3'(ROUND_LAT - 1) : 3'd0;

    typedef enum logic [2:0] {IDLE, LOAD, INIT, ROUND, WAIT, FINAL, DONE} state_t;

    state_t       state, state_nxt;
    logic [3:0]   word_cnt;
    logic [5:0]   t;
    logic [2:0]   lat_cnt;
    logic [n-1:0] w [0:15];
    logic [n-1:0] h [0:m-1];
    logic [n-1:0] w_new;
    logic         hs;

    function automatic logic [n-1:0] rotr(input logic [n-1:0] x, input int r);
        return (x >> r) | (x << (n - r));
    endfunction

    function automatic logic [n-1:0] sig0(input logic [n-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [n-1:0] sig1(input logic [n-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // w[0] is W_t for the current round; the newly produced word is W_(t+16).
    assign w_new = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];
    assign hs    = blk.blk_valid_i && blk.blk_ready_o;

    assign dp_w_o    = w[0];
    assign dp_k_o    = K[t];
    assign dp_init_o = h;
    assign digest_o  = h;
    assign busy_o    = (state != IDLE);

    always_comb begin
        state_nxt       = state;
        dp_load_o       = 1'b0;
        dp_step_o       = 1'b0;
        digest_valid_o  = 1'b0;
        blk.blk_ready_o = 1'b0;
        unique case (state)
            IDLE: begin
                blk.blk_ready_o = rst_i;
                if (blk.blk_valid_i) state_nxt = LOAD;
            end
            LOAD: begin
                blk.blk_ready_o = rst_i;
                if (blk.blk_valid_i && word_cnt == 4'd15) state_nxt = INIT;
            end
            INIT: begin
                dp_load_o = 1'b1;
                state_nxt = ROUND;
            end
            ROUND: begin
                dp_step_o = 1'b1;
                if (ROUND_LAT > 0)    state_nxt = WAIT;
                else if (t == 6'd63)  state_nxt = FINAL;
                else                  state_nxt = ROUND;
            end
            WAIT: begin
                // t has already advanced past the step just issued, so it reads
                // 0 here only after the 64th step.
                if (lat_cnt == LAT_LAST) state_nxt = (t == 6'd0) ? FINAL : ROUND;
            end
            FINAL: state_nxt = DONE;
            DONE: begin
                digest_valid_o = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            word_cnt <= 4'd0;
            t        <= 6'd0;
            lat_cnt  <= 3'd0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
            for (int j = 0; j < m; j++)  h[j] <= IV[j];
        end else begin
            state <= state_nxt;
            if (hs) begin
                for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                w[15]    <= blk.blk_word_i;
                // 4-bit counter wraps to 0 on the 16th word, ready for the next block
                word_cnt <= (state == IDLE) ? 4'd1 : word_cnt + 4'd1;
                if (state == IDLE && blk.blk_first_i) begin
                    for (int j = 0; j < m; j++) h[j] <= IV[j];
                end
            end
            if (state == ROUND) begin
                for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                w[15]   <= w_new;
                t       <= t + 6'd1;
                lat_cnt <= 3'd0;
            end
            if (state == WAIT) lat_cnt <= lat_cnt + 3'd1;
            if (state == FINAL) begin
                for (int j = 0; j < m; j++) h[j] <= h[j] + dp_state_i[j];
            end
        end
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
module tb_sha256_round_ctrl;

    typedef logic [0:7][31:0]  hv_t;
    typedef logic [0:15][31:0] blk_t;
    typedef logic [0:63][31:0] sch_t;

    localparam logic [31:0] KT [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam hv_t IVH = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam hv_t ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam hv_t TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int r);
        return (x >> r) | (x << (32 - r));
    endfunction

    function automatic sch_t expand(input blk_t b);
        sch_t s;
        for (int i = 0; i < 16; i++) s[i] = b[i];
        for (int i = 16; i < 64; i++)
            s[i] = (rotr(s[i-2], 17) ^ rotr(s[i-2], 19) ^ (s[i-2] >> 10)) + s[i-7]
                 + (rotr(s[i-15], 7) ^ rotr(s[i-15], 18) ^ (s[i-15] >> 3)) + s[i-16];
        return s;
    endfunction

    function automatic hv_t round_fn(input hv_t s, input logic [31:0] wt, input logic [31:0] kt);
        logic [31:0] t1, t2;
        hv_t r;
        t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
           + ((s[4] & s[5]) ^ (~s[4] & s[6])) + kt + wt;
        t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
           + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
        r = {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
        return r;
    endfunction

    function automatic hv_t compress(input hv_t hin, input blk_t b);
        sch_t wv;
        hv_t  s;
        hv_t  hout;
        wv = expand(b);
        s  = hin;
        for (int i = 0; i < 64; i++) s = round_fn(s, wv[i], KT[i]);
        for (int j = 0; j < 8; j++) hout[j] = hin[j] + s[j];
        return hout;
    endfunction

    // ---------------- clock, DUTs, datapath models ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        tb_valid;
    logic [31:0] tb_word;
    logic        tb_first;

    sha256_round_ctrl_if bus1 ();
    sha256_round_ctrl_if bus3 ();
    assign bus1.blk_valid_i = tb_valid & ~sel;
    assign bus3.blk_valid_i = tb_valid & sel;
    assign bus1.blk_word_i  = tb_word;
    assign bus3.blk_word_i  = tb_word;
    assign bus1.blk_first_i = tb_first;
    assign bus3.blk_first_i = tb_first;

    logic        d1_load, d1_step, d1_dv, d1_busy, d3_load, d3_step, d3_dv, d3_busy;
    logic [31:0] d1_w, d1_k, d3_w, d3_k;
    logic [31:0] d1_init [0:7], d1_st [0:7], d1_dig [0:7];
    logic [31:0] d3_init [0:7], d3_st [0:7], d3_dig [0:7];
    hv_t         dp1, dp3, dig1, dig3;

    sha256_round_ctrl #(.n(32), .m(8), .ROUND_LAT(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .blk(bus1),
        .dp_load_o(d1_load), .dp_init_o(d1_init), .dp_step_o(d1_step),
        .dp_w_o(d1_w), .dp_k_o(d1_k), .dp_state_i(d1_st),
        .digest_o(d1_dig), .digest_valid_o(d1_dv), .busy_o(d1_busy)
    );

    sha256_round_ctrl #(.n(32), .m(8), .ROUND_LAT(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .blk(bus3),
        .dp_load_o(d3_load), .dp_init_o(d3_init), .dp_step_o(d3_step),
        .dp_w_o(d3_w), .dp_k_o(d3_k), .dp_state_i(d3_st),
        .digest_o(d3_dig), .digest_valid_o(d3_dv), .busy_o(d3_busy)
    );

    // Round datapath models: state is valid one cycle after each step.
    always @(posedge clk) begin
        if (d1_load)      for (int j = 0; j < 8; j++) dp1[j] <= d1_init[j];
        else if (d1_step) dp1 <= round_fn(dp1, d1_w, d1_k);
        if (d3_load)      for (int j = 0; j < 8; j++) dp3[j] <= d3_init[j];
        else if (d3_step) dp3 <= round_fn(dp3, d3_w, d3_k);
    end

    always_comb begin
        for (int j = 0; j < 8; j++) begin
            d1_st[j] = dp1[j];
            d3_st[j] = dp3[j];
            dig1[j]  = d1_dig[j];
            dig3[j]  = d3_dig[j];
        end
    end

    // ---------------- monitor of the selected DUT ----------------
    wire         m_ready = sel ? bus3.blk_ready_o : bus1.blk_ready_o;
    wire         m_load  = sel ? d3_load : d1_load;
    wire         m_step  = sel ? d3_step : d1_step;
    wire         m_dv    = sel ? d3_dv : d1_dv;
    wire         m_busy  = sel ? d3_busy : d1_busy;
    wire  [31:0] m_w     = sel ? d3_w : d1_w;
    wire  [31:0] m_k     = sel ? d3_k : d1_k;
    hv_t         m_dig;
    assign m_dig = sel ? dig3 : dig1;

    int          cyc = 0;
    int          hs_cnt = 0, step_cnt = 0, dv_cnt = 0, gap_bad = 0;
    int          load_cyc = 0, first_step_cyc = 0, last_step_cyc = 0, dv_cyc = 0;
    logic [31:0] cap_w [0:63];
    logic [31:0] cap_k [0:63];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tb_valid && m_ready) hs_cnt <= hs_cnt + 1;
        if (m_load) begin
            step_cnt <= 0;
            load_cyc <= cyc;
        end
        if (m_step) begin
            if (step_cnt < 64) begin
                cap_w[step_cnt] <= m_w;
                cap_k[step_cnt] <= m_k;
            end
            if (step_cnt == 0) first_step_cyc <= cyc;
            else if (cyc - last_step_cyc != (sel ? 4 : 2)) gap_bad <= gap_bad + 1;
            last_step_cyc <= cyc;
            step_cnt      <= step_cnt + 1;
        end
        if (m_dv) begin
            dv_cnt <= dv_cnt + 1;
            dv_cyc <= cyc;
        end
    end

    // ---------------- checking helpers ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Sends one block; returns the cycle of the 16th handshake.
    task automatic send_block(input blk_t b, input logic first, input int maxgap, output int c16);
        int   budget;
        logic seen;
        c16 = 0;
        for (int i = 0; i < 16; i++) begin
            repeat ((maxgap > 0) ? $urandom_range(maxgap, 0) : 0) begin
                tb_valid = 1'b0;
                tb_word  = $urandom;
                @(posedge clk); #1;
            end
            tb_valid = 1'b1;
            tb_word  = b[i];
            tb_first = (i == 0) ? first : 1'($urandom_range(1, 0));
            budget   = 0;
            seen     = 1'b0;
            while (!seen && budget < 300) begin
                @(negedge clk);
                seen = m_ready;
                if (seen && i == 15) c16 = cyc;
                @(posedge clk); #1;
                budget++;
            end
            if (!seen) begin
                chk("word_accept_timeout", 0, 1);
                tb_valid = 1'b0;
                return;
            end
        end
        tb_valid = 1'b0;
    endtask

    task automatic wait_dv(input int dv0);
        int budget = 0;
        while (dv_cnt == dv0 && budget < 600) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("digest_valid_seen", (dv_cnt > dv0), 1);
    endtask

    // ---------------- directed sequence ----------------
    blk_t abc_b, b1, b2, rb;
    hv_t  href;
    sch_t wref;
    int   c16, dv0, hs0, wbad, kbad, budget;

    initial begin
        rst = 1'b0; sel = 1'b0; tb_valid = 1'b0; tb_word = '0; tb_first = 1'b0;
        abc_b = '0; abc_b[0] = 32'h61626380; abc_b[15] = 32'h00000018;
        b1 = '0; b2 = '0;
        for (int j = 0; j < 14; j++)
            b1[j] = {8'(97 + j), 8'(98 + j), 8'(99 + j), 8'(100 + j)};
        b1[14] = 32'h80000000;
        b2[15] = 32'h000001c0;

        // reset state
        #12;
        chk("rst_ready", m_ready, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_load", m_load, 0);
        chk("rst_step", m_step, 0);
        chk("rst_dv", m_dv, 0);
        chk("rst_w", m_w, 0);
        chk("rst_k", m_k, 32'h428a2f98);
        chk("rst_digest", dig1, IVH);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_release", m_ready, 1);
        @(posedge clk); #1;

        // "abc", unthrottled, L=1
        dv0 = dv_cnt; hs0 = hs_cnt;
        send_block(abc_b, 1'b1, 0, c16);
        wait_dv(dv0);
        wref = expand(abc_b);
        chk("abc_digest", dig1, ABC);
        chk("abc_model", dig1, compress(IVH, abc_b));
        chk("abc_dv_cycle", dv_cyc - c16, 131);
        chk("abc_load_cycle", load_cyc - c16, 1);
        chk("abc_step0_cycle", first_step_cyc - c16, 2);
        chk("abc_steps", step_cnt, 64);
        chk("abc_step_spacing", gap_bad, 0);
        chk("abc_dv_count", dv_cnt - dv0, 1);
        chk("abc_handshakes", hs_cnt - hs0, 16);
        chk("w16", cap_w[16], 32'h61626380);
        chk("w17", cap_w[17], 32'h000f0000);
        chk("w63", cap_w[63], wref[63]);
        chk("k63", cap_k[63], 32'hc67178f2);
        wbad = 0; kbad = 0;
        for (int i = 0; i < 64; i++) begin
            if (cap_w[i] !== wref[i]) wbad++;
            if (cap_k[i] !== KT[i]) kbad++;
        end
        chk("w_all_bad", wbad, 0);
        chk("k_all_bad", kbad, 0);

        // two-block message
        dv0 = dv_cnt;
        send_block(b1, 1'b1, 0, c16);
        wait_dv(dv0);
        href = compress(IVH, b1);
        chk("two_blk1_model", dig1, href);
        chk("two_blk1_dv_count", dv_cnt - dv0, 1);
        dv0 = dv_cnt;
        send_block(b2, 1'b0, 0, c16);
        wait_dv(dv0);
        chk("two_final_digest", dig1, TWO);
        chk("two_final_model", dig1, compress(href, b2));
        chk("two_blk2_dv_count", dv_cnt - dv0, 1);

        // throttled "abc" with words offered while busy
        dv0 = dv_cnt; hs0 = hs_cnt;
        send_block(abc_b, 1'b1, 5, c16);
        chk("thr_handshakes", hs_cnt - hs0, 16);
        tb_valid = 1'b1;
        repeat (100) begin
            tb_word = $urandom;
            @(posedge clk); #1;
        end
        tb_valid = 1'b0;
        chk("thr_no_consume_busy", hs_cnt - hs0, 16);
        wait_dv(dv0);
        chk("thr_digest", dig1, ABC);

        // random blocks: first, then continuation
        for (int i = 0; i < 16; i++) rb[i] = $urandom;
        dv0 = dv_cnt;
        send_block(rb, 1'b1, 2, c16);
        wait_dv(dv0);
        href = compress(IVH, rb);
        chk("rand_first_model", dig1, href);
        for (int i = 0; i < 16; i++) rb[i] = $urandom;
        dv0 = dv_cnt;
        send_block(rb, 1'b0, 2, c16);
        wait_dv(dv0);
        href = compress(href, rb);
        chk("rand_cont_model", dig1, href);

        // reset during round 30 of a continuation block
        dv0 = dv_cnt;
        send_block(abc_b, 1'b0, 0, c16);
        budget = 0;
        while (!(m_step && step_cnt == 30) && budget < 300) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("reach_step30", (m_step && step_cnt == 30), 1);
        rst = 1'b0;
        #1;
        chk("midrst_digest_iv", dig1, IVH);
        chk("midrst_busy", m_busy, 0);
        chk("midrst_step", m_step, 0);
        chk("midrst_ready", m_ready, 0);
        chk("midrst_w", m_w, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_dv", dv_cnt - dv0, 0);
        send_block(abc_b, 1'b0, 0, c16);
        wait_dv(dv0);
        chk("midrst_abc_digest", dig1, ABC);
        chk("midrst_dv_count", dv_cnt - dv0, 1);

        // ROUND_LAT = 3 instance
        sel = 1'b1;
        @(posedge clk); #1;
        dv0 = dv_cnt;
        send_block(abc_b, 1'b1, 0, c16);
        wait_dv(dv0);
        chk("lat3_digest", dig3, ABC);
        chk("lat3_dv_cycle", dv_cyc - c16, 259);
        chk("lat3_steps", step_cnt, 64);
        chk("lat3_step_spacing", gap_bad, 0);
        chk("lat3_dv_count", dv_cnt - dv0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
